// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, one Booth step per clock, with start/busy/done handshake.
// Produces the full 2*WIDTH product plus a truncated or saturated WIDTH-bit result.
module booth_mult_seq #(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     operand_1,
  input  logic [WIDTH-1:0]     operand_2,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     result,
  output logic                 overflow
);

  localparam int PW = 2*WIDTH + 3;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_next;
  logic [PW-1:0]     p_reg, p_step;
  logic [WIDTH:0]    m_reg;
  logic [CW-1:0]     count;
  logic              mode_signed;
  logic              accept, last_step;
  logic [WIDTH:0]    ext_1, ext_2, acc, acc_sum;
  logic [2*WIDTH-1:0] prod_final;
  logic              ovf_final;
  logic [WIDTH-1:0]  res_final;

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_step  = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept     = 1'b1;
        state_next = RUN;
      end
      RUN: if (count == LAST) begin
        last_step  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  // One extra extension bit keeps the most negative operand exact in signed mode.
  always_comb begin
    ext_1 = signed_mode ? {operand_1[WIDTH-1], operand_1} : {1'b0, operand_1};
    ext_2 = signed_mode ? {operand_2[WIDTH-1], operand_2} : {1'b0, operand_2};
    acc   = p_reg[PW-1:WIDTH+2];
    case (p_reg[1:0])
      2'b01:   acc_sum = acc + m_reg;
      2'b10:   acc_sum = acc + ~m_reg + (WIDTH+1)'(1);
      default: acc_sum = acc;
    endcase
    p_step     = {acc_sum[WIDTH], acc_sum, p_reg[WIDTH+1:1]};
    prod_final = p_step[2*WIDTH:1];
    if (mode_signed)
      ovf_final = !((&prod_final[2*WIDTH-1:WIDTH-1]) || !(|prod_final[2*WIDTH-1:WIDTH-1]));
    else
      ovf_final = |prod_final[2*WIDTH-1:WIDTH];
    res_final = prod_final[WIDTH-1:0];
    if (SATURATE && ovf_final) begin
      if (!mode_signed)               res_final = {WIDTH{1'b1}};
      else if (prod_final[2*WIDTH-1]) res_final = {1'b1, {(WIDTH-1){1'b0}}};
      else                            res_final = {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      p_reg       <= '0;
      m_reg       <= '0;
      count       <= '0;
      mode_signed <= 1'b0;
      done        <= 1'b0;
      product     <= '0;
      result      <= '0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        p_reg       <= {{(WIDTH+1){1'b0}}, ext_2, 1'b0};
        m_reg       <= ext_1;
        count       <= '0;
        mode_signed <= signed_mode;
      end else if (state == RUN) begin
        p_reg <= p_step;
        count <= count + CW'(1);
        if (last_step) begin
          product  <= prod_final;
          result   <= res_final;
          overflow <= ovf_final;
          done     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq: arithmetic reference model, cycle-level handshake model,
// and a monitor that pops expected results whenever the DUT pulses done.
module tb_booth_mult_seq;

  localparam int WIDTH = 16;

  typedef struct {
    logic [31:0] prod;
    logic [15:0] res_sat;
    logic [15:0] res_trunc;
    logic        ovf;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [15:0] operand_1 = '0;
  logic [15:0] operand_2 = '0;
  logic        busy, done, overflow;
  logic [31:0] product;
  logic [15:0] result;
  logic        busy_t, done_t, overflow_t;
  logic [31:0] product_t;
  logic [15:0] result_t;

  int tests = 0;
  int errors = 0;

  exp_t sb[$];
  exp_t held;
  bit   m_busy = 1'b0;
  bit   m_done = 1'b0;
  bit   m_reset = 1'b0;
  int   m_rem = 0;

  booth_mult_seq #(.WIDTH(WIDTH), .SATURATE(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .signed_mode(signed_mode),
    .operand_1(operand_1), .operand_2(operand_2), .busy(busy), .done(done),
    .product(product), .result(result), .overflow(overflow)
  );

  booth_mult_seq #(.WIDTH(WIDTH), .SATURATE(1'b0)) dut_trunc (
    .clock(clock), .reset_n(reset_n), .start(start), .signed_mode(signed_mode),
    .operand_1(operand_1), .operand_2(operand_2), .busy(busy_t), .done(done_t),
    .product(product_t), .result(result_t), .overflow(overflow_t)
  );

  always #5 clock = ~clock;

  function automatic exp_t refMult(input logic [15:0] a, input logic [15:0] b, input logic sm);
    exp_t e;
    longint x, y, p;
    logic [63:0] pv;
    x = sm ? longint'($signed(a)) : longint'(a);
    y = sm ? longint'($signed(b)) : longint'(b);
    p = x * y;
    pv = p;
    e.prod      = pv[31:0];
    e.ovf       = sm ? (p < -32768 || p > 32767) : (p > 65535);
    e.res_trunc = pv[15:0];
    if (!e.ovf)   e.res_sat = pv[15:0];
    else if (!sm) e.res_sat = 16'hFFFF;
    else          e.res_sat = (p < 0) ? 16'h8000 : 16'h7FFF;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Transaction-level model: acceptance, fixed latency, reset abandoning in-flight work.
  always @(posedge clock) begin
    m_done  = 1'b0;
    m_reset = 1'b0;
    if (!reset_n) begin
      m_busy  = 1'b0;
      m_rem   = 0;
      m_reset = 1'b1;
      sb.delete();
    end else if (m_busy) begin
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else if (start) begin
      sb.push_back(refMult(operand_1, operand_2, signed_mode));
      m_busy = 1'b1;
      m_rem  = WIDTH + 1;
    end
  end

  always @(negedge clock) begin
    if (m_reset) begin
      held.prod = '0; held.res_sat = '0; held.res_trunc = '0; held.ovf = 1'b0;
    end
    checkOutput("busy", 64'(busy), 64'(m_busy));
    checkOutput("done", 64'(done), 64'(m_done));
    if (done) begin
      if (sb.size() == 0) checkOutput("done_without_request", 64'(1), 64'(0));
      else held = sb.pop_front();
    end
    checkOutput("product", 64'(product), 64'(held.prod));
    checkOutput("result", 64'(result), 64'(held.res_sat));
    checkOutput("overflow", 64'(overflow), 64'(held.ovf));
    checkOutput("result_trunc", 64'(result_t), 64'(held.res_trunc));
    checkOutput("overflow_trunc", 64'(overflow_t), 64'(held.ovf));
  end

  task automatic waitIdle();
    int guard = 0;
    while (m_busy && guard < 200) begin
      @(posedge clock); #2;
      guard++;
    end
    checkOutput("idle_timeout", 64'(m_busy), 64'(0));
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic sm, input bit noise);
    int guard = 0;
    waitIdle();
    operand_1 = a; operand_2 = b; signed_mode = sm; start = 1'b1;
    @(posedge clock); #2;
    start = 1'b0;
    while (m_busy && guard < 200) begin
      if (noise) begin
        start = 1'($urandom); operand_1 = 16'($urandom);
        operand_2 = 16'($urandom); signed_mode = 1'($urandom);
      end
      @(posedge clock); #2;
      guard++;
    end
    start = 1'b0;
  endtask

  function automatic logic [15:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'hFFFF;
      3: return 16'h8000;
      4: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b1;

    applyStimulus(16'hFFFD, 16'd5, 1'b1, 1'b0);
    applyStimulus(16'h8000, 16'h8000, 1'b1, 1'b0);
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    applyStimulus(16'd300, 16'd200, 1'b0, 1'b0);
    applyStimulus(16'd300, 16'd200, 1'b1, 1'b0);

    waitIdle();
    operand_1 = 16'd7; operand_2 = 16'd9; signed_mode = 1'b0; start = 1'b1;
    @(posedge clock); #2 start = 1'b0;
    repeat (7) @(posedge clock);
    #2 reset_n = 1'b0;
    @(posedge clock); #2 reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    applyStimulus(16'd7, 16'd9, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(pickOperand(), pickOperand(), 1'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock); #2;
      end
    end

    waitIdle();
    start = 1'b1;
    for (int c = 0; c < 92; c++) begin
      operand_1 = 16'($urandom); operand_2 = 16'($urandom); signed_mode = 1'($urandom);
      @(posedge clock); #2;
    end
    start = 1'b0;
    waitIdle();
    repeat (3) @(posedge clock);
    #2;
    checkOutput("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/booth_mult_seq.md
# booth_mult_seq

Parametrised sequential radix-2 Booth multiplier for the ALU datapath. It multiplies two WIDTH-bit operands in signed or unsigned mode, one Booth step per clock. It presents a full 2·WIDTH-bit product plus a WIDTH-bit result that is either truncated or saturated, with a start/busy/done handshake. It replaces free-running, counter-gated multiplication with an explicit, restartable transaction on the main clock.

## Interface
- WIDTH, 16, operand width; legal range 4..32.
- SATURATE, 1, 1 = `result` saturates on overflow; 0 = `result` is `product[WIDTH-1:0]`.

- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  reset, active-low, synchronous.
- start  in  1  request; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement operands; 0 = unsigned. Latched with the operands.
- operand_1  in  WIDTH  multiplicand; latched when start is accepted.
- operand_2  in  WIDTH  multiplier; latched when start is accepted.
- busy  out  1  high while a multiply is in progress (state RUN).
- done  out  1  one-cycle pulse when `product`, `result` and `overflow` update.
- product  out  2·WIDTH  full product, registered; holds until the next completion.
- result  out  WIDTH  narrow result per SATURATE, registered.
- overflow  out  1  full product is not representable in WIDTH bits in the latched mode; registered.

## Operation
- States: IDLE, RUN.
- IDLE, start=1 at an edge:
  - Extend each operand to WIDTH+1 bits: sign-extend if signed_mode, else zero-extend.
  - Load P = {(WIDTH+1)'b0, ext(operand_2), 1'b0}. P is 2·WIDTH+3 bits.
  - Load M = ext(operand_1) and the step counter to 0.
  - Latch the mode; go to RUN.
- RUN, each edge, one Booth step on P[1:0]:
  - 01: add M to the upper WIDTH+1 bits.
  - 10: subtract M (add ~M+1) from the upper WIDTH+1 bits.
  - 00 and 11: no add.
  - Then arithmetic-shift P right by 1, replicating the MSB.
  - Increment the counter.
- Every run takes WIDTH+1 steps, in both modes.
  - Step WIDTH+1 is the final step. On that edge the registered outputs take the final shifted value: `product` = P[2·WIDTH:1] low 2·WIDTH bits.
  - Also on that edge: `overflow` and `result` load, done is set, and the state returns to IDLE.
- Overflow:
  - Signed: product[2·WIDTH-1:WIDTH-1] is not all-equal.
  - Unsigned: product[2·WIDTH-1:WIDTH] is nonzero.
- Saturation (SATURATE=1, overflow=1):
  - Signed: 2^(WIDTH-1)-1 if product[2·WIDTH-1]=0, else -2^(WIDTH-1).
  - Unsigned: all ones.
  - Otherwise `result` = product[WIDTH-1:0].
- Operand, mode and start inputs are ignored while busy. Operand inputs may change freely after acceptance.
- The most negative operand (e.g. 0x8000 × 0x8000 signed) must produce the exact product. The extra extension bit guarantees this.

## Timing
- Reset (reset_n=0 at an edge) has priority over everything:
  - State goes to IDLE.
  - busy=0, done=0, product=0, result=0, overflow=0.
  - The counter and P clear.
  - An in-flight multiply is abandoned; no done is issued.
- Start is accepted at edge k while in IDLE. busy=1 from after edge k through edge k+WIDTH+1.
- Final step at edge k+WIDTH+1. After that edge: done=1, busy=0, outputs valid. Latency is WIDTH+1 cycles (17 for WIDTH=16).
- done is high for exactly one cycle and clears at the next edge unless a new completion occurs.
- start high in the done cycle is accepted (state is IDLE): back-to-back throughput of one result per WIDTH+2 cycles.
- Outputs change only on a completion edge or a reset.
- Holding start high continuously restarts immediately after each completion.

## Test plan
- WIDTH=16, SATURATE=1:
  - signed, -3 × 5 → after 17 cycles done pulses; product=0xFFFF_FFF1, result=0xFFF1, overflow=0.
  - signed, 0x8000 × 0x8000 → product=0x4000_0000, overflow=1, result=0x7FFF.
  - unsigned, 0xFFFF × 0xFFFF → product=0xFFFE_0001, overflow=1, result=0xFFFF.
- 300 × 200:
  - unsigned → product=0x0000_EA60, overflow=0, result=0xEA60.
  - signed → same product, overflow=1, result=0x7FFF.
  - SATURATE=0, signed → result=0xEA60, overflow=1.
- Reset mid-operation: start 7 × 9, drive reset_n=0 at step 8 → busy=0, product=0, no done. Restart 7 × 9 → product=63 after 17 cycles.
- Handshake: start held high with operands changed during RUN → done every 18 cycles. Each product matches the operands latched at its acceptance. Start pulses while busy are ignored.
